// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings
// and the default stability window and counter width.
package debounce_pkg;

    // Default number of consecutive synchronized cycles needed to accept a level change.
    localparam int unsigned DEFAULT_STABLE_CYCLES = 32'd4;

    // Default stability counter width; must be able to hold STABLE_CYCLES-1.
    localparam int unsigned DEFAULT_CNT_W = 32'd16;

    // Debounce FSM states.
    // IDLE         : button accepted as released
    // PRESS_WAIT   : synchronized input high, counting towards acceptance
    // PRESSED      : button accepted as pressed
    // RELEASE_WAIT : synchronized input low, counting towards release acceptance
    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous button input into
// the clk domain. Both flops clear on the synchronous reset so that a
// button still held after reset is seen as a fresh rising level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Two-stage metastability filter; only s2_r is consumed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer with press/release strobes and a wrapping press
// counter. The raw input is synchronized, then a four-state FSM requires
// STABLE_CYCLES+1 consecutive synchronized samples at the new level before
// accepting a change. All outputs are registered.
module btn_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    // Terminal count: the FSM accepts the level on the sample that finds
    // the counter already at STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             s2_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pulse_r;
    logic             release_r;
    logic [7:0]       count_r;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2_s)
    );

    // Debounce FSM with stability counter, registered level, strobes and press counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            pulse_r   <= 1'b0;
            release_r <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            pulse_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (s2_s) begin
                        state_r <= ST_PRESS_WAIT;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= cnt_r;
                    end
                    level_r <= 1'b0;
                end

                ST_PRESS_WAIT: begin
                    if (s2_s) begin
                        if (cnt_r == CNT_LAST) begin
                            // Press accepted: one strobe and one count per press.
                            state_r <= ST_PRESSED;
                            cnt_r   <= CNT_ZERO;
                            level_r <= 1'b1;
                            pulse_r <= 1'b1;
                            count_r <= count_r + 8'd1;
                        end else begin
                            state_r <= ST_PRESS_WAIT;
                            cnt_r   <= cnt_r + CNT_ONE;
                            level_r <= 1'b0;
                        end
                    end else begin
                        // Bounce back low before acceptance: drop the attempt.
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        level_r <= 1'b0;
                    end
                end

                ST_PRESSED: begin
                    if (!s2_s) begin
                        state_r <= ST_RELEASE_WAIT;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_PRESSED;
                        cnt_r   <= cnt_r;
                    end
                    level_r <= 1'b1;
                end

                ST_RELEASE_WAIT: begin
                    if (!s2_s) begin
                        if (cnt_r == CNT_LAST) begin
                            // Release accepted.
                            state_r   <= ST_IDLE;
                            cnt_r     <= CNT_ZERO;
                            level_r   <= 1'b0;
                            release_r <= 1'b1;
                        end else begin
                            state_r <= ST_RELEASE_WAIT;
                            cnt_r   <= cnt_r + CNT_ONE;
                            level_r <= 1'b1;
                        end
                    end else begin
                        // Bounce back high: still pressed, no new press strobe.
                        state_r <= ST_PRESSED;
                        cnt_r   <= CNT_ZERO;
                        level_r <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a known released state.
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level     = level_r;
    assign btn_pulse     = pulse_r;
    assign release_pulse = release_r;
    assign press_count   = count_r;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed testbench for btn_debounce_pulse (STABLE_CYCLES = 4).
// Inputs change on the falling edge; outputs are observed on the falling
// edge, half a period after the rising edge that updated them.
module tb_btn_debounce_pulse;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       btn_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int rel_cnt = 0;
    bit overlap_seen = 1'b0;

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .btn_pulse     (btn_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count)
    );

    // Tally strobes just after each rising edge and note any overlap.
    always @(posedge clk) begin
        #1;
        if (btn_pulse === 1'b1) pulse_cnt++;
        if (release_pulse === 1'b1) rel_cnt++;
        if (btn_pulse === 1'b1 && release_pulse === 1'b1) overlap_seen = 1'b1;
    end

    // Time limit so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", btn_level); end
        checks++;
        if (btn_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", btn_pulse); end
        checks++;
        if (release_pulse !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", release_pulse); end
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", press_count); end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse, release_pulse, press_count} !== 11'd0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got lvl=%b p=%b r=%b cnt=%0d want all 0",
                         i, btn_level, btn_pulse, release_pulse, press_count);
            end
        end
    endtask

    task automatic test_press;
        int  p0;
        logic exp_p;
        logic exp_l;
        p0 = pulse_cnt;
        for (int i = 1; i <= 20; i++) begin
            btn_in = 1'b1;
            @(negedge clk);
            exp_p = (i == 7) ? 1'b1 : 1'b0;
            exp_l = (i >= 7) ? 1'b1 : 1'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL press_pulse edge %0d got %b want %b", i, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL press_level edge %0d got %b want %b", i, btn_level, exp_l); end
        end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL press_count got %0d want 1", press_count); end
        checks++;
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL press_strobes got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_release_bounce;
        int  r0;
        int  p0;
        logic exp_r;
        logic exp_l;
        r0 = rel_cnt;
        p0 = pulse_cnt;
        for (int i = 1; i <= 16; i++) begin
            btn_in = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_r = (i == 10) ? 1'b1 : 1'b0;
            exp_l = (i < 10) ? 1'b1 : 1'b0;
            checks++;
            if (release_pulse !== exp_r) begin errors++; $display("FAIL release_pulse edge %0d got %b want %b", i, release_pulse, exp_r); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL release_level edge %0d got %b want %b", i, btn_level, exp_l); end
        end
        checks++;
        if (rel_cnt - r0 !== 1) begin errors++; $display("FAIL release_strobes got %0d want 1", rel_cnt - r0); end
        checks++;
        if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL release_no_press got %0d want 0", pulse_cnt - p0); end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL release_count got %0d want 1", press_count); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulse_cnt;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 8; i++) begin
                btn_in = (i < 4) ? 1'b1 : 1'b0;
                @(negedge clk);
                checks++;
                if (btn_pulse !== 1'b0) begin errors++; $display("FAIL glitch_pulse burst %0d cycle %0d got %b want 0", g, i, btn_pulse); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", pulse_cnt - p0); end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL glitch_count got %0d want 1", press_count); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch_level got %b want 0", btn_level); end
    endtask

    task automatic test_min_press;
        logic exp_p;
        logic exp_r;
        for (int i = 1; i <= 20; i++) begin
            btn_in = (i <= 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_p = (i == 7) ? 1'b1 : 1'b0;
            exp_r = (i == 12) ? 1'b1 : 1'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL minpress_pulse edge %0d got %b want %b", i, btn_pulse, exp_p); end
            checks++;
            if (release_pulse !== exp_r) begin errors++; $display("FAIL minpress_release edge %0d got %b want %b", i, release_pulse, exp_r); end
        end
        checks++;
        if (press_count !== 8'd2) begin errors++; $display("FAIL minpress_count got %0d want 2", press_count); end
    endtask

    task automatic test_wrap;
        int p0;
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL wrap_start_count got %0d want 0", press_count); end
        p0 = pulse_cnt;
        for (int n = 1; n <= 257; n++) begin
            btn_in = 1'b1;
            repeat (8) @(negedge clk);
            btn_in = 1'b0;
            repeat (10) @(negedge clk);
            if (n == 256) begin
                checks++;
                if (press_count !== 8'd0) begin errors++; $display("FAIL wrap_256_count got %0d want 0", press_count); end
                checks++;
                if (pulse_cnt - p0 !== 256) begin errors++; $display("FAIL wrap_256_strobes got %0d want 256", pulse_cnt - p0); end
            end
        end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", press_count); end
        checks++;
        if (pulse_cnt - p0 !== 257) begin errors++; $display("FAIL wrap_strobes got %0d want 257", pulse_cnt - p0); end
    endtask

    task automatic test_reset_mid;
        logic exp_p;
        int   p0;
        // Enter PRESS_WAIT, then reset while the button stays held.
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== 2'b00) begin errors++; $display("FAIL midreset_hold cycle %0d got lvl=%b p=%b want 0 0", i, btn_level, btn_pulse); end
        end
        checks++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", press_count); end
        rst = 1'b0;
        p0 = pulse_cnt;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_p = (i == 7) ? 1'b1 : 1'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL midreset_pulse edge %0d got %b want %b", i, btn_pulse, exp_p); end
        end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL midreset_after_count got %0d want 1", press_count); end
        // Reset while PRESSED: level drops, held button becomes a new press.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL pressedreset_level got %b want 0", btn_level); end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_p = (i == 7) ? 1'b1 : 1'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL pressedreset_pulse edge %0d got %b want %b", i, btn_pulse, exp_p); end
        end
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL pressedreset_count got %0d want 1", press_count); end
        checks++;
        if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL reset_strobes got %0d want 2", pulse_cnt - p0); end
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL final_level got %b want 0", btn_level); end
    endtask

    task automatic test_exclusive;
        checks++;
        if (overlap_seen !== 1'b0) begin errors++; $display("FAIL strobe_overlap got %b want 0", overlap_seen); end
    endtask

    initial begin
        rst = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_press();
        test_release_bounce();
        test_glitch();
        test_min_press();
        test_wrap();
        test_reset_mid();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized cycles required to accept a level change (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stability counter width; it SHALL hold STABLE_CYCLES-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port btn_in, input, 1, raw asynchronous bouncing push-button.
REQ-006 SHALL have port btn_level, output, 1, debounced button level.
REQ-007 SHALL have port btn_pulse, output, 1, one-cycle strobe on each accepted press; this is the clock/enable feeding the divider stage downstream.
REQ-008 SHALL have port release_pulse, output, 1, one-cycle strobe on each accepted release.
REQ-009 SHALL have port press_count, output, 8, count of accepted presses, wrapping modulo 256.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; only the second flop output (s2) is used by the FSM.
REQ-011 SHALL implement an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 In IDLE with s2=1, the FSM SHALL go to PRESS_WAIT and clear the counter; with s2=0 it SHALL stay in IDLE.
REQ-013 In PRESS_WAIT with s2=1 and counter==STABLE_CYCLES-1, the FSM SHALL go to PRESSED; with s2=1 otherwise, the counter SHALL increment; with s2=0, the FSM SHALL return to IDLE and clear the counter.
REQ-014 PRESSED and RELEASE_WAIT SHALL mirror IDLE and PRESS_WAIT with s2 inverted, returning to IDLE on an accepted release.
REQ-015 btn_level SHALL be 1 exactly while in PRESSED or RELEASE_WAIT (registered).
REQ-016 btn_pulse SHALL be high for exactly the one cycle following the PRESS_WAIT->PRESSED transition; release_pulse likewise for RELEASE_WAIT->IDLE.
REQ-017 Latency SHALL be STABLE_CYCLES+3 rising edges from the first edge sampling btn_in=1 to btn_pulse=1 (7 at default).
REQ-018 An s2 high run of <= STABLE_CYCLES cycles SHALL produce no pulse, and a run of STABLE_CYCLES+1 SHALL produce exactly one pulse.
REQ-019 press_count SHALL increment in the same cycle btn_pulse asserts and SHALL wrap 255->0 with no flag.
REQ-020 btn_pulse and release_pulse SHALL never be high in the same cycle; each press SHALL produce at most one btn_pulse regardless of hold time.

Reset
REQ-021 While rst=1 at a clock edge: state SHALL be IDLE; the counter, synchronizer flops, btn_level, btn_pulse, release_pulse and press_count SHALL all be 0.
REQ-022 Reset asserted mid-debounce or while PRESSED SHALL abort with no pulse; if the button is still held after release of reset, it SHALL be re-debounced and counted as a new press.

Structure
REQ-023 FSM state encodings (2-bit) and the default STABLE_CYCLES SHALL live in a shared package, debounce_pkg.
REQ-024 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, rst, d, q).

Verification
REQ-025 Apply rst=1 for 2 cycles, then btn_in=0 for 10 cycles -> all outputs remain 0.
REQ-026 Hold btn_in=1 for 20 cycles -> btn_pulse high for exactly 1 cycle, 7 edges after the first 1 is sampled; btn_level=1; press_count=1.
REQ-027 Apply 4-cycle btn_in glitches separated by 4-cycle lows, 5 times -> btn_pulse never asserts; press_count stays 0.
REQ-028 Press, then release with bounce (1,0,1,0 single cycles, then 0 held) -> exactly one release_pulse after 7 stable-low edges; btn_level=0.
REQ-029 Perform 257 clean presses -> press_count=1 after wrap; 257 btn_pulse strobes counted.
REQ-030 Assert rst during PRESS_WAIT while btn_in is held high, then deassert -> no pulse during reset; one btn_pulse 7 edges after rst deasserts.
